// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the floating-point datapath. This package holds the
// FCLASS bit positions used by the classifier, plus the exponent-bias and
// width helpers that the add/mul/fma units also use.
// ---------------------------------------------------------------------------
package fp_pkg;

    // One-hot FCLASS bit positions (RISC-V ordering)
    localparam int FCLS_NINF  = 0;
    localparam int FCLS_NNORM = 1;
    localparam int FCLS_NSUB  = 2;
    localparam int FCLS_NZERO = 3;
    localparam int FCLS_PZERO = 4;
    localparam int FCLS_PSUB  = 5;
    localparam int FCLS_PNORM = 6;
    localparam int FCLS_PINF  = 7;
    localparam int FCLS_SNAN  = 8;
    localparam int FCLS_QNAN  = 9;
    localparam int FCLS_W     = 10;

    // Exponent bias for an NEXP-bit exponent field
    function automatic int fp_bias(input int nexp);
        return (1 << (nexp - 1)) - 1;
    endfunction

    // Width of a leading-zero count able to represent 0..w
    function automatic int fp_lzc_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// ---------------------------------------------------------------------------
// fp_lzc
// Combinational leading-zero counter.
// Ports:
//   i_d    [W-1:0]            value to scan, MSB first
//   o_cnt  [$clog2(W+1)-1:0]  number of leading zeros; all-zero input gives W
// ---------------------------------------------------------------------------
module fp_lzc #(
    parameter int W = 23
) (
    input  logic [W-1:0]             i_d,
    output logic [$clog2(W+1)-1:0]   o_cnt
);

    localparam int CW = $clog2(W + 1);

    // Scanning upward lets the highest set bit overwrite any lower one.
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_d[i]) begin
                o_cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_unpack_pipe.sv
// ---------------------------------------------------------------------------
// fp_unpack_pipe
// Two-stage IEEE-754 classifier/unpacker with valid/ready handshakes.
// Produces the 10-bit FCLASS mask, sign, unbiased two's-complement exponent
// and significand with an explicit hidden bit. Subnormals are normalised.
//
// Build option: define FP_UNPACK_DAZ_EN to treat subnormal inputs as signed
// zero (denormals-are-zero); the leading-zero count and shifter are removed.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational from out_ready)
//   in_f                raw operand {sign, exp[NEXP], frac[NSIG]}
//   in_tag              sideband tag carried with the operand
//   out_valid/out_ready output handshake
//   out_class           one-hot FCLASS mask
//   out_sign            operand sign (also for NaN)
//   out_exp             unbiased exponent, NEXP+2 bits signed
//   out_sig             significand, hidden bit at MSB
//   out_tag             tag of this result
// ---------------------------------------------------------------------------
module fp_unpack_pipe
    import fp_pkg::*;
#(
    parameter int NEXP  = 8,
    parameter int NSIG  = 23,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NEXP+NSIG:0]       in_f,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FCLS_W-1:0]        out_class,
    output logic                     out_sign,
    output logic signed [NEXP+1:0]   out_exp,
    output logic [NSIG:0]            out_sig,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int EW   = NEXP + 2;
    localparam int BIAS = fp_bias(NEXP);
    localparam logic signed [EW-1:0] BIAS_S      = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_SPECIAL = EW'(BIAS + 1);

    // Handshake: a stage may load when it is empty or its successor loads.
    logic w_s2_en;
    logic w_s1_en;

    logic r_vld_p1;
    logic r_vld_p2;

    assign w_s2_en  = !r_vld_p2 || out_ready;
    assign w_s1_en  = !r_vld_p1 || w_s2_en;
    assign in_ready = w_s1_en;

    // ---------------- Stage 0 -> 1: field decode, class mask, LZC ----------
    logic              w_sign_p0;
    logic [NEXP-1:0]   w_e_p0;
    logic [NSIG-1:0]   w_frac_p0;
    logic              w_exp_ones_p0;
    logic              w_exp_zeros_p0;
    logic              w_frac_zero_p0;
    logic [FCLS_W-1:0] w_class_p0;

    assign w_sign_p0      = in_f[NEXP+NSIG];
    assign w_e_p0         = in_f[NEXP+NSIG-1:NSIG];
    assign w_frac_p0      = in_f[NSIG-1:0];
    assign w_exp_ones_p0  = &w_e_p0;
    assign w_exp_zeros_p0 = ~|w_e_p0;
    assign w_frac_zero_p0 = ~|w_frac_p0;

    always_comb begin
        w_class_p0 = '0;
        if (w_exp_ones_p0) begin
            if (w_frac_zero_p0) begin
                w_class_p0[w_sign_p0 ? FCLS_NINF : FCLS_PINF] = 1'b1;
            end else if (w_frac_p0[NSIG-1]) begin
                w_class_p0[FCLS_QNAN] = 1'b1;
            end else begin
                w_class_p0[FCLS_SNAN] = 1'b1;
            end
        end else if (w_exp_zeros_p0) begin
`ifdef FP_UNPACK_DAZ_EN
            w_class_p0[w_sign_p0 ? FCLS_NZERO : FCLS_PZERO] = 1'b1;
`else
            if (w_frac_zero_p0) begin
                w_class_p0[w_sign_p0 ? FCLS_NZERO : FCLS_PZERO] = 1'b1;
            end else begin
                w_class_p0[w_sign_p0 ? FCLS_NSUB : FCLS_PSUB] = 1'b1;
            end
`endif
        end else begin
            w_class_p0[w_sign_p0 ? FCLS_NNORM : FCLS_PNORM] = 1'b1;
        end
    end

`ifndef FP_UNPACK_DAZ_EN
    localparam int LZW = fp_lzc_w(NSIG);

    logic [LZW-1:0] w_lz_p0;
    logic [LZW-1:0] r_lz_p1;

    fp_lzc #(
        .W (NSIG)
    ) u_lzc (
        .i_d   (w_frac_p0),
        .o_cnt (w_lz_p0)
    );

    // Only the count is registered; the shift happens in stage 2.
    always_ff @(posedge clk) begin
        if (w_s1_en && in_valid) begin
            r_lz_p1 <= w_lz_p0;
        end
    end
`endif

    logic              r_sign_p1;
    logic [NEXP-1:0]   r_e_p1;
    logic [NSIG-1:0]   r_frac_p1;
    logic [FCLS_W-1:0] r_class_p1;
    logic [TAG_W-1:0]  r_tag_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_en) begin
            r_vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_en && in_valid) begin
            r_sign_p1  <= w_sign_p0;
            r_e_p1     <= w_e_p0;
            r_frac_p1  <= w_frac_p0;
            r_class_p1 <= w_class_p0;
            r_tag_p1   <= in_tag;
        end
    end

    // ---------------- Stage 1 -> 2: shift and exponent adjust --------------
    logic                   w_is_special_p1;
    logic                   w_is_norm_p1;
    logic signed [EW-1:0]   w_exp_p1;
    logic [NSIG:0]          w_sig_p1;

    assign w_is_special_p1 = r_class_p1[FCLS_NINF] | r_class_p1[FCLS_PINF]
                           | r_class_p1[FCLS_SNAN] | r_class_p1[FCLS_QNAN];
    assign w_is_norm_p1    = r_class_p1[FCLS_NNORM] | r_class_p1[FCLS_PNORM];

`ifndef FP_UNPACK_DAZ_EN
    logic            w_is_sub_p1;
    logic [NSIG-1:0] w_shift_p1;

    assign w_is_sub_p1 = r_class_p1[FCLS_NSUB] | r_class_p1[FCLS_PSUB];
    // Shift by lz+1 pushes the leading one out; it becomes the hidden bit.
    assign w_shift_p1  = {r_frac_p1[NSIG-2:0], 1'b0} << r_lz_p1;
`endif

    always_comb begin
        w_exp_p1 = '0;
        w_sig_p1 = '0;
        if (w_is_special_p1) begin
            w_exp_p1 = EXP_SPECIAL;
            w_sig_p1 = {1'b0, r_frac_p1};
        end else if (w_is_norm_p1) begin
            w_exp_p1 = $signed({2'b00, r_e_p1}) - BIAS_S;
            w_sig_p1 = {1'b1, r_frac_p1};
`ifndef FP_UNPACK_DAZ_EN
        end else if (w_is_sub_p1) begin
            // 1 - BIAS - (lz + 1) folds to -BIAS - lz
            w_exp_p1 = -BIAS_S - $signed(EW'(r_lz_p1));
            w_sig_p1 = {1'b1, w_shift_p1};
`endif
        end
    end

    logic [FCLS_W-1:0]    r_class_p2;
    logic                 r_sign_p2;
    logic signed [EW-1:0] r_exp_p2;
    logic [NSIG:0]        r_sig_p2;
    logic [TAG_W-1:0]     r_tag_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2   <= 1'b0;
            r_class_p2 <= '0;
            r_sign_p2  <= 1'b0;
            r_exp_p2   <= '0;
            r_sig_p2   <= '0;
            r_tag_p2   <= '0;
        end else if (w_s2_en) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_class_p2 <= r_class_p1;
                r_sign_p2  <= r_sign_p1;
                r_exp_p2   <= w_exp_p1;
                r_sig_p2   <= w_sig_p1;
                r_tag_p2   <= r_tag_p1;
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign out_class = r_class_p2;
    assign out_sign  = r_sign_p2;
    assign out_exp   = r_exp_p2;
    assign out_sig   = r_sig_p2;
    assign out_tag   = r_tag_p2;

endmodule
